fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between the fetch stage and decode. Captures each fetched instruction word with its PC and PC+4 into a small synchronous FIFO and presents the oldest entry to decode. Replaces the plain IF/ID register: absorbs decode stalls without immediately freezing the PC, and discards all buffered instructions on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- NOP, 32'h00000013, instruction presented to decode when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ValidF  input  1  fetch presents a valid instruction this cycle.
- InstrF  input  32  fetched instruction word.
- PCF  input  32  PC of InstrF.
- PCPlus4F  input  32  PCF+4.
- FullF  output  1  queue cannot accept; fetch must hold its PC.
- StallD  input  1  decode cannot consume the head this cycle.
- FlushD  input  1  redirect (PCSrcE != 0); discard all entries.
- ValidD  output  1  head entry is valid.
- InstrD  output  32  head instruction, or NOP when empty.
- PCD  output  32  head PC, or 0 when empty.
- PCPlus4D  output  32  head PC+4, or 0 when empty.
- CountD  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- State: storage array of DEPTH entries {instr, pc, pcplus4}, write pointer, read pointer ($clog2(DEPTH) bits, wrap naturally), count.
- pop = ValidD && !StallD && !FlushD.
- push = ValidF && !FullF && !FlushD.
- FullF = (count == DEPTH) && StallD. When full and decode consumes, a push in the same cycle is accepted.
- push: write entry at wptr, wptr+1 mod DEPTH.
- pop: rptr+1 mod DEPTH.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- FlushD has priority over everything: next cycle count=0, rptr=wptr=0. A same-cycle ValidF entry is dropped.
- Head outputs are combinational from storage[rptr] when count != 0, else InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0.
- Push while empty is not bypassed to the outputs. The entry appears the following cycle.
- ValidF with FullF high: fetch holds the same instruction; the queue does not capture it, so there is no duplication.

## Timing
- Reset: count=0, pointers=0, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0, FullF=0, CountD=0. Reset mid-operation discards all entries identically to flush.
- Latency: instruction accepted at edge N is on InstrD in cycle N+1 if the queue was empty. Otherwise it appears after all older entries are popped.
- Throughput: one push and one pop per cycle sustained. With StallD low, behaviour equals a single IF/ID register.
- FullF depends combinationally on StallD only; there is no path from ValidF to FullF.
- Flush in cycle N: ValidD=0 in cycle N+1. The first post-redirect instruction pushed in N+1 is visible in N+2.
- Wrap-around: pointers wrap modulo DEPTH with no bubble. count distinguishes full from empty.

## Structure
- Shared package fetch_pkg: typedef fq_entry_t {logic [31:0] instr, pc, pcplus4}; constant NOP_INSTR = 32'h00000013; used by fetch, decode and the hazard unit.
- Sub-module fq_storage: DEPTH-entry register array with single write port (we, waddr, wdata) and combinational read port (raddr, rdata). No reset on data; pointer and count logic stays in fetch_queue.
- Hazard unit drives StallD and FlushD. The fetch PC-hold enable becomes StallF | FullF.

## Test plan
- Reset: assert rst 2 cycles with ValidF=1 -> ValidD=0, InstrD=32'h00000013, CountD=0, FullF=0 throughout and on the first cycle after release.
- Streaming: push PCF=0,4,8,... InstrF=PC^32'hA5A5_0000, StallD=0 -> each entry appears exactly one cycle later in order, CountD stays at 1, FullF never asserts.
- Fill and stall (DEPTH=4): StallD=1, push PCs 0x10..0x1C -> CountD=4, FullF=1. Hold 3 cycles with ValidF=1 and PCF=0x20 -> no capture. Release StallD -> 0x10, 0x14, 0x18, 0x1C, 0x20 in order, and 0x20 is pushed in the release cycle.
- Flush with concurrent push: queue holds 3 entries, FlushD=1 and ValidF=1 (PCF=0x40) -> next cycle ValidD=0, CountD=0; PCF=0x80 pushed after -> InstrD/PCD=0x80 one cycle later.
- Wrap-around: 10 pushes with random StallD (seeded) -> output PC sequence equals input sequence, CountD never exceeds 4, with no loss or duplication across pointer wrap.
- Mid-operation reset: 2 entries queued, rst=1 for one cycle -> identical state to the power-on reset checks.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by fetch, decode and the hazard unit.
//   fq_entry_t : one buffered fetch record {instr, pc, pcplus4}
//   NOP_INSTR  : addi x0,x0,0, presented to decode when nothing is buffered
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } fq_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch -> decode handshake bundle around the fetch queue.
//   master : fetch/hazard side (drives the fetched word, StallD, FlushD)
//   slave  : the queue (drives FullF and the decode-side head outputs)
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          ValidF;
    logic [31:0]   InstrF;
    logic [31:0]   PCF;
    logic [31:0]   PCPlus4F;
    logic          FullF;
    logic          StallD;
    logic          FlushD;
    logic          ValidD;
    logic [31:0]   InstrD;
    logic [31:0]   PCD;
    logic [31:0]   PCPlus4D;
    logic [CW-1:0] CountD;

    modport master (
        output ValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
        input  FullF, ValidD, InstrD, PCD, PCPlus4D, CountD
    );

    modport slave (
        input  ValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
        output FullF, ValidD, InstrD, PCD, PCPlus4D, CountD
    );

endinterface

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry register array for the fetch queue.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address (combinational read)
//   rdata_o : entry at raddr_i
// Data is deliberately not reset; validity is tracked by the queue count.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fq_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fq_entry_t     rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO between fetch and decode replacing the IF/ID register.
//   clk, rst : clock, synchronous active-high reset
//   fq.*     : fetch side (ValidF/InstrF/PCF/PCPlus4F -> FullF),
//              decode side (StallD/FlushD -> ValidD/InstrD/PCD/PCPlus4D/CountD)
// Head outputs are combinational from storage; an empty queue shows NOP.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic      full_s;
    logic      nonempty_s;
    logic      push_s;
    logic      pop_s;
    fq_entry_t wdata_s;
    fq_entry_t head_s;

    // Full only blocks fetch while decode is also stalled: a consuming
    // decode frees the slot the same cycle. No path from ValidF here.
    assign full_s     = (count_q == CW'(DEPTH)) && fq.StallD;
    assign nonempty_s = (count_q != {CW{1'b0}});
    assign pop_s      = nonempty_s && !fq.StallD && !fq.FlushD;
    assign push_s     = fq.ValidF && !full_s && !fq.FlushD;

    assign wdata_s = '{instr: fq.InstrF, pc: fq.PCF, pcplus4: fq.PCPlus4F};

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk     (clk),
        .we_i    (push_s && !rst),
        .waddr_i (wptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rptr_q),
        .rdata_o (head_s)
    );

    // Next-state pointers and occupancy; flush clears everything.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fq.FlushD) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Head presentation: stored entry when non-empty, NOP bubble otherwise.
    always_comb begin
        if (nonempty_s) begin
            fq.ValidD   = 1'b1;
            fq.InstrD   = head_s.instr;
            fq.PCD      = head_s.pc;
            fq.PCPlus4D = head_s.pcplus4;
        end else begin
            fq.ValidD   = 1'b0;
            fq.InstrD   = NOP;
            fq.PCD      = 32'h0000_0000;
            fq.PCPlus4D = 32'h0000_0000;
        end
    end

    assign fq.FullF  = full_s;
    assign fq.CountD = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .NOP(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    fq_entry_t   model[$];
    logic [31:0] out_pcs[$];

    logic          s_valid;
    logic [31:0]   s_instr;
    logic [31:0]   s_pcd;
    logic [CW-1:0] s_count;
    logic          s_full;

    typedef struct {
        logic          v;
        logic [31:0]   pc;
        logic          st;
        logic          e_valid;
        logic [31:0]   e_pcd;
        logic [CW-1:0] e_cnt;
        logic          e_full;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample/compare against the scoreboard,
    // then advance the scoreboard at the rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic st,
                        input logic fl, input logic rs);
        fq_entry_t e;
        bit full_m, pop_m, push_m;
        @(negedge clk);
        rst          = rs;
        bus.ValidF   = v;
        bus.InstrF   = pc ^ 32'hA5A5_0000;
        bus.PCF      = pc;
        bus.PCPlus4F = pc + 32'd4;
        bus.StallD   = st;
        bus.FlushD   = fl;
        #1;
        s_valid = bus.ValidD;
        s_instr = bus.InstrD;
        s_pcd   = bus.PCD;
        s_count = bus.CountD;
        s_full  = bus.FullF;
        if (model.size() != 0) e = model[0];
        else e = '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd0};
        chk("sb_valid", {31'd0, bus.ValidD}, {31'd0, model.size() != 0});
        chk("sb_instr", bus.InstrD, e.instr);
        chk("sb_pc", bus.PCD, e.pc);
        chk("sb_pcplus4", bus.PCPlus4D, e.pcplus4);
        chk("sb_count", 32'(bus.CountD), 32'(model.size()));
        full_m = (model.size() == DEPTH) && st;
        chk("sb_full", {31'd0, bus.FullF}, {31'd0, full_m});
        if (bus.ValidD && !st && !fl && !rs) out_pcs.push_back(bus.PCD);
        @(posedge clk);
        if (rs || fl) begin
            model.delete();
        end else begin
            pop_m  = (model.size() != 0) && !st;
            push_m = v && !full_m;
            if (pop_m) void'(model.pop_front());
            if (push_m) model.push_back('{instr: pc ^ 32'hA5A5_0000, pc: pc, pcplus4: pc + 32'd4});
        end
    endtask

    initial begin
        int idx;
        int r;
        bit st_r;
        bit acc;
        logic [31:0] pc_w;

        n_tests = 0;
        n_fail  = 0;

        // Fill-and-stall vectors: {ValidF, PCF, StallD | ValidD, PCD, CountD, FullF}
        tbl[0]  = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h10, 3'd1, 1'b0};
        tbl[2]  = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h10, 3'd2, 1'b0};
        tbl[3]  = '{1'b1, 32'h1C, 1'b1, 1'b1, 32'h10, 3'd3, 1'b0};
        tbl[4]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h10, 3'd4, 1'b1};
        tbl[5]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h10, 3'd4, 1'b1};
        tbl[6]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h10, 3'd4, 1'b1};
        tbl[7]  = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h10, 3'd4, 1'b0};
        tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h14, 3'd4, 1'b0};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h18, 3'd3, 1'b0};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h1C, 3'd2, 1'b0};
        tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h20, 3'd1, 1'b0};
        tbl[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0};

        rst          = 1'b1;
        bus.ValidF   = 1'b1;
        bus.InstrF   = 32'h0;
        bus.PCF      = 32'h300;
        bus.PCPlus4F = 32'h304;
        bus.StallD   = 1'b0;
        bus.FlushD   = 1'b0;
        @(posedge clk);

        // Reset with ValidF held high, then first cycle after release.
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        chk("rst_instr", s_instr, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_rel_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_rel_count", 32'(s_count), 32'd0);

        // Streaming: behaves like a single IF/ID register.
        out_pcs.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0);
            if (i > 0) begin
                chk("stream_pcd", s_pcd, 32'(4 * (i - 1)));
                chk("stream_count", 32'(s_count), 32'd1);
                chk("stream_full", {31'd0, s_full}, 32'd0);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stream_last", s_pcd, 32'd28);

        // Flush with a concurrent push.
        step(1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h54, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h58, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        chk("flush_pre_count", 32'(s_count), 32'd3);
        step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", {31'd0, s_valid}, 32'd0);
        chk("flush_count", 32'(s_count), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_next_pc", s_pcd, 32'h80);
        chk("flush_next_instr", s_instr, 32'h80 ^ 32'hA5A5_0000);

        // Fill and stall, table driven.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].st, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pcd", i), s_pcd, tbl[i].e_pcd);
            chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_full", i), {31'd0, s_full}, {31'd0, tbl[i].e_full});
        end

        // Wrap-around with seeded random decode stalls.
        r = $urandom(32'd1234);
        idx = 0;
        out_pcs.delete();
        for (int c = 0; c < 200 && !(idx == 10 && model.size() == 0); c++) begin
            st_r = 1'($urandom_range(1, 0));
            pc_w = 32'h100 + 32'(4 * idx);
            acc  = (idx < 10) && !((model.size() == DEPTH) && st_r);
            step(idx < 10, pc_w, st_r, 1'b0, 1'b0);
            if (acc) idx++;
        end
        chk("wrap_pop_count", 32'(out_pcs.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < out_pcs.size()) chk("wrap_order", out_pcs[i], 32'h100 + 32'(4 * i));
        end

        // Mid-operation reset.
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b1, 1'b0, 1'b1);
        chk("mrst_pre_count", 32'(s_count), 32'd2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("mrst_valid", {31'd0, s_valid}, 32'd0);
        chk("mrst_instr", s_instr, 32'h0000_0013);
        chk("mrst_pcd", s_pcd, 32'd0);
        chk("mrst_count", 32'(s_count), 32'd0);
        chk("mrst_full", {31'd0, s_full}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
